store_commit_unit: RTL and testbench
====================================

// Module: store_commit_unit
// PURPOSE
//  Drains retired stores from the store queue FIFO and writes them to data memory.
//  Retirement grants one credit per retired store. Per credit the unit pops one entry
//  (single-cycle dequeue_request pulse), captures the registered entry, and holds a
//  valid/ready memory write until accepted. Sits between store queue dequeue port and D-mem/D-cache.
// PARAMETERS
//  STORE_QUEUE_DEPTH  `LSQ_SZ  max outstanding credits (= store queue depth)
//  RETIRE_WIDTH       2        max stores retired per cycle
// PORTS
//  clock                        in   1             system clock
//  reset                        in   1             synchronous, active-high
//  retire_store_count_i         in   $clog2(RETIRE_WIDTH+1)  stores retired this cycle
//  dequeue_request_o            out  1             pop request to store queue
//  dequeue_accepted_i           in   1             queue pop pulse (1 cycle after request)
//  dequeue_store_address_i      in   $bits(ADDR)   popped address
//  dequeue_store_data_i         in   $bits(DATA)   popped data
//  dequeue_store_byte_enable_i  in   $bits(DATA)/8 popped byte enables
//  mem_write_valid_o            out  1             memory write request valid
//  mem_write_address_o          out  $bits(ADDR)   write address
//  mem_write_data_o             out  $bits(DATA)   write data
//  mem_write_byte_enable_o      out  $bits(DATA)/8 write byte enables
//  mem_write_ready_i            in   1             memory accepts when valid&&ready
//  store_committed_o            out  1             1-cycle pulse, cycle after write handshake
//  commit_idle_o                out  1             IDLE state and zero credits
//  credit_error_o               out  1             sticky: credit overflow or empty-queue pop
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, credits=0, every output 0, except
//    commit_idle_o=1. Reset mid-operation drops any in-flight store.
//  - Credit counter credits_q, width $clog2(STORE_QUEUE_DEPTH+1):
//    credits_next = credits_q + retire_store_count_i - (dequeue_accepted_i in WAIT_POP).
//    If credits_next > STORE_QUEUE_DEPTH: saturate at DEPTH, set credit_error_o.
//    Increment and decrement in the same cycle net out.
//  - FSM IDLE/POP/WAIT_POP/WRITE:
//    IDLE: credits_q>0 -> POP.
//    POP: dequeue_request_o=1 for exactly this cycle (never 2 consecutive) -> WAIT_POP.
//    WAIT_POP, dequeue_accepted_i=1: latch addr/data/be into mem_write_*_o,
//      set mem_write_valid_o, consume 1 credit -> WRITE.
//    WAIT_POP, dequeue_accepted_i=0: queue was empty; set credit_error_o,
//      keep credit -> IDLE (retry).
//    WRITE: hold valid and payload stable until mem_write_ready_i=1. On handshake:
//      drop valid, pulse store_committed_o next cycle; credits_q>0 -> POP, else IDLE.
//  - Payload stays unchanged while valid && !ready; no new pop while in WRITE.
//  - Latency: credit at edge t -> dequeue_request_o in cycle t+1 -> accepted sampled t+2
//    -> mem_write_valid_o t+3. With ready=1, steady-state one store per 3 cycles.
//  - dequeue_accepted_i outside WAIT_POP is ignored and sets credit_error_o.
//  - credit_error_o clears only on reset.
// TESTING
//  1 Single store: count=1, queue {A=0x100,D=0xDEADBEEF,BE=0xF}, ready=1 -> one 1-cycle
//    dequeue_request_o, valid at t+3 with that payload, committed pulse t+4, idle after.
//  2 Backpressure: ready=0 for 5 cycles -> valid and payload stable 5 cycles, no second
//    pop; commit once when ready=1.
//  3 Burst: count=2 then count=1, 3 entries queued -> 3 writes in FIFO order, never two
//    consecutive dequeue_request_o cycles, credits end at 0.
//  4 Simultaneous: count=1 in the same cycle as an accept, with credits=1 -> credits stays 1.
//  5 Error: credit with empty queue -> no accept, credit_error_o=1, retry pop after fill
//    succeeds. Overflow: DEPTH+1 credits -> saturate at DEPTH, error set.
//  6 Reset in WRITE with valid=1 -> next cycle all outputs 0, commit_idle_o=1, credits=0.

Source files
------------

// File: rtl/store_commit_unit.sv
// rtl/store_commit_unit.sv - drains retired stores from the store queue into data memory
// One credit per retired store; each credit pops one queue entry and issues one memory write.
module store_commit_unit #(
  parameter int STORE_QUEUE_DEPTH = 8,
  parameter int RETIRE_WIDTH      = 2,
  parameter int ADDR_W            = 32,
  parameter int DATA_W            = 32,
  localparam int CNT_W            = $clog2(RETIRE_WIDTH + 1),
  localparam int CRED_W           = $clog2(STORE_QUEUE_DEPTH + 1),
  localparam int BE_W             = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  retire_store_count_i,
  output logic              dequeue_request_o,
  input  logic              dequeue_accepted_i,
  input  logic [ADDR_W-1:0] dequeue_store_address_i,
  input  logic [DATA_W-1:0] dequeue_store_data_i,
  input  logic [BE_W-1:0]   dequeue_store_byte_enable_i,
  output logic              mem_write_valid_o,
  output logic [ADDR_W-1:0] mem_write_address_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic [BE_W-1:0]   mem_write_byte_enable_o,
  input  logic              mem_write_ready_i,
  output logic              store_committed_o,
  output logic              commit_idle_o,
  output logic              credit_error_o
);

  localparam int SUM_W = CRED_W + CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT_POP,
    S_WRITE
  } state_e;

  state_e            state_q;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic [SUM_W-1:0]  credit_sum;
  logic              consume;
  logic              overflow;

  logic              dequeue_request_q;
  logic              mem_write_valid_q;
  logic [ADDR_W-1:0] mem_write_address_q;
  logic [DATA_W-1:0] mem_write_data_q;
  logic [BE_W-1:0]   mem_write_byte_enable_q;
  logic              store_committed_q;
  logic              commit_idle_q;
  logic              credit_error_q;

  // A credit is only consumed by an accepted pop; retirements and consumption net out.
  always_comb begin
    consume    = (state_q == S_WAIT_POP) && dequeue_accepted_i;
    credit_sum = SUM_W'(credits_q) + SUM_W'(retire_store_count_i) - SUM_W'(consume);
    overflow   = credit_sum > SUM_W'(STORE_QUEUE_DEPTH);
    credits_d  = overflow ? CRED_W'(STORE_QUEUE_DEPTH) : credit_sum[CRED_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                 <= S_IDLE;
      credits_q               <= '0;
      dequeue_request_q       <= 1'b0;
      mem_write_valid_q       <= 1'b0;
      mem_write_address_q     <= '0;
      mem_write_data_q        <= '0;
      mem_write_byte_enable_q <= '0;
      store_committed_q       <= 1'b0;
      commit_idle_q           <= 1'b1;
      credit_error_q          <= 1'b0;
    end else begin
      credits_q         <= credits_d;
      dequeue_request_q <= 1'b0;
      store_committed_q <= 1'b0;
      commit_idle_q     <= 1'b0;
      if (overflow || (dequeue_accepted_i && state_q != S_WAIT_POP)) begin
        credit_error_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (credits_q != '0) begin
            state_q           <= S_POP;
            dequeue_request_q <= 1'b1;
          end else begin
            commit_idle_q <= (credits_d == '0);
          end
        end
        S_POP: begin
          state_q <= S_WAIT_POP;
        end
        S_WAIT_POP: begin
          if (dequeue_accepted_i) begin
            mem_write_address_q     <= dequeue_store_address_i;
            mem_write_data_q        <= dequeue_store_data_i;
            mem_write_byte_enable_q <= dequeue_store_byte_enable_i;
            mem_write_valid_q       <= 1'b1;
            state_q                 <= S_WRITE;
          end else begin
            // Queue had nothing to give: keep the credit and retry from IDLE.
            credit_error_q <= 1'b1;
            state_q        <= S_IDLE;
            commit_idle_q  <= (credits_d == '0);
          end
        end
        S_WRITE: begin
          if (mem_write_ready_i) begin
            mem_write_valid_q <= 1'b0;
            store_committed_q <= 1'b1;
            if (credits_q != '0) begin
              state_q           <= S_POP;
              dequeue_request_q <= 1'b1;
            end else begin
              state_q       <= S_IDLE;
              commit_idle_q <= (credits_d == '0);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dequeue_request_o       = dequeue_request_q;
  assign mem_write_valid_o       = mem_write_valid_q;
  assign mem_write_address_o     = mem_write_address_q;
  assign mem_write_data_o        = mem_write_data_q;
  assign mem_write_byte_enable_o = mem_write_byte_enable_q;
  assign store_committed_o       = store_committed_q;
  assign commit_idle_o           = commit_idle_q;
  assign credit_error_o          = credit_error_q;

endmodule

// File: tb/tb_store_commit_unit.sv
// tb/tb_store_commit_unit.sv - scoreboard bench for store_commit_unit
// A small store-queue model feeds pops; expected writes are queued when stores are loaded.
module tb_store_commit_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  retire_store_count_i = '0;
  logic        dequeue_request_o;
  logic        dequeue_accepted_i = 1'b0;
  logic [31:0] dequeue_store_address_i = '0;
  logic [31:0] dequeue_store_data_i = '0;
  logic [3:0]  dequeue_store_byte_enable_i = '0;
  logic        mem_write_valid_o;
  logic [31:0] mem_write_address_o;
  logic [31:0] mem_write_data_o;
  logic [3:0]  mem_write_byte_enable_o;
  logic        mem_write_ready_i = 1'b1;
  logic        store_committed_o;
  logic        commit_idle_o;
  logic        credit_error_o;

  store_commit_unit #(.STORE_QUEUE_DEPTH(DEPTH), .RETIRE_WIDTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .retire_store_count_i        (retire_store_count_i),
    .dequeue_request_o           (dequeue_request_o),
    .dequeue_accepted_i          (dequeue_accepted_i),
    .dequeue_store_address_i     (dequeue_store_address_i),
    .dequeue_store_data_i        (dequeue_store_data_i),
    .dequeue_store_byte_enable_i (dequeue_store_byte_enable_i),
    .mem_write_valid_o           (mem_write_valid_o),
    .mem_write_address_o         (mem_write_address_o),
    .mem_write_data_o            (mem_write_data_o),
    .mem_write_byte_enable_o     (mem_write_byte_enable_o),
    .mem_write_ready_i           (mem_write_ready_i),
    .store_committed_o           (store_committed_o),
    .commit_idle_o               (commit_idle_o),
    .credit_error_o              (credit_error_o)
  );

  always #5 clock = ~clock;

  int  total = 0;
  int  bad = 0;
  int  pops = 0;
  int  writes = 0;
  st_t q_mem[$];
  st_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_t s;
    s.a = a; s.d = d; s.be = be;
    q_mem.push_back(s);
    exp_q.push_back(s);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int budget;
    budget = 200;
    while (writes < n && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, writes, n);
  endtask

  // Queue model and output monitor, evaluated 1 ns after each falling edge.
  logic pend = 1'b0;
  logic prev_req = 1'b0;
  logic prev_stall = 1'b0;
  logic expect_commit = 1'b0;
  st_t  prev_pl;
  always begin
    st_t s, e;
    @(negedge clock);
    #1;
    if (reset) begin
      pend = 1'b0;
      dequeue_accepted_i = 1'b0;
      prev_req = 1'b0;
      prev_stall = 1'b0;
      expect_commit = 1'b0;
    end else begin
      dequeue_accepted_i = 1'b0;
      if (pend && q_mem.size() > 0) begin
        s = q_mem.pop_front();
        dequeue_accepted_i = 1'b1;
        dequeue_store_address_i = s.a;
        dequeue_store_data_i = s.d;
        dequeue_store_byte_enable_i = s.be;
      end
      pend = dequeue_request_o;
      if (dequeue_request_o) begin
        pops++;
        check("req_not_consecutive", prev_req, 1'b0);
      end
      prev_req = dequeue_request_o;
      if (expect_commit || store_committed_o) check("commit_pulse", store_committed_o, expect_commit);
      if (prev_stall) begin
        check("stall_valid", mem_write_valid_o, 1'b1);
        check("stall_addr", mem_write_address_o, prev_pl.a);
        check("stall_data", mem_write_data_o, prev_pl.d);
        check("stall_be", mem_write_byte_enable_o, prev_pl.be);
      end
      prev_stall = mem_write_valid_o && !mem_write_ready_i;
      prev_pl.a = mem_write_address_o;
      prev_pl.d = mem_write_data_o;
      prev_pl.be = mem_write_byte_enable_o;
      expect_commit = mem_write_valid_o && mem_write_ready_i;
      if (expect_commit) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_write_address_o, e.a);
          check("wr_data", mem_write_data_o, e.d);
          check("wr_be", mem_write_byte_enable_o, e.be);
        end
      end
    end
  end

  initial begin
    int budget;
    int pops_snap;
    tick(); tick();
    check("rst_req", dequeue_request_o, 1'b0);
    check("rst_valid", mem_write_valid_o, 1'b0);
    check("rst_commit", store_committed_o, 1'b0);
    check("rst_idle", commit_idle_o, 1'b1);
    check("rst_err", credit_error_o, 1'b0);
    check("rst_credits", dut.credits_q, 0);
    reset = 1'b0;
    tick();

    // Single store with exact latency.
    push_store(32'h100, 32'hDEADBEEF, 4'hF);
    retire_store_count_i = 2'd1;
    tick(); retire_store_count_i = 2'd0;
    check("t1_req_early", dequeue_request_o, 1'b0);
    tick(); check("t1_req", dequeue_request_o, 1'b1);
    tick(); check("t1_req_drop", dequeue_request_o, 1'b0);
    check("t1_valid_early", mem_write_valid_o, 1'b0);
    tick(); check("t1_valid", mem_write_valid_o, 1'b1);
    check("t1_addr", mem_write_address_o, 32'h100);
    check("t1_data", mem_write_data_o, 32'hDEADBEEF);
    check("t1_be", mem_write_byte_enable_o, 4'hF);
    tick(); check("t1_committed", store_committed_o, 1'b1);
    check("t1_valid_drop", mem_write_valid_o, 1'b0);
    tick(); check("t1_idle", commit_idle_o, 1'b1);
    check("t1_pops", pops, 1);
    check("t1_writes", writes, 1);

    // Backpressure: write held for 5 cycles, no further pop.
    mem_write_ready_i = 1'b0;
    push_store(32'h204, 32'h12345678, 4'h3);
    retire_store_count_i = 2'd1;
    tick(); retire_store_count_i = 2'd0;
    budget = 20;
    while (!mem_write_valid_o && budget > 0) begin tick(); budget--; end
    check("t2_valid_seen", mem_write_valid_o, 1'b1);
    pops_snap = pops;
    for (int i = 0; i < 5; i++) tick();
    check("t2_no_pop", pops, pops_snap);
    check("t2_writes_held", writes, 1);
    mem_write_ready_i = 1'b1;
    wait_writes(2, "t2_commit");

    // Burst of three in FIFO order.
    push_store(32'h300, 32'hA0A0A0A0, 4'h1);
    push_store(32'h304, 32'hB1B1B1B1, 4'h2);
    push_store(32'h308, 32'hC2C2C2C2, 4'hC);
    retire_store_count_i = 2'd2;
    tick(); retire_store_count_i = 2'd1;
    tick(); retire_store_count_i = 2'd0;
    wait_writes(5, "t3_writes");
    tick(); tick();
    check("t3_credits", dut.credits_q, 0);
    check("t3_idle", commit_idle_o, 1'b1);

    // Retire arriving in the same cycle as an accept nets out.
    push_store(32'h400, 32'h44444444, 4'hF);
    push_store(32'h404, 32'h55555555, 4'hF);
    retire_store_count_i = 2'd1;
    tick(); retire_store_count_i = 2'd0;
    budget = 20;
    while (!dequeue_request_o && budget > 0) begin tick(); budget--; end
    check("t4_req_seen", dequeue_request_o, 1'b1);
    tick(); retire_store_count_i = 2'd1;
    tick(); retire_store_count_i = 2'd0;
    check("t4_credits", dut.credits_q, 1);
    wait_writes(7, "t4_writes");
    tick(); tick();
    check("t4_credits_end", dut.credits_q, 0);

    // Credit with an empty queue: error, retry succeeds after fill.
    check("t5_err_before", credit_error_o, 1'b0);
    retire_store_count_i = 2'd1;
    tick(); retire_store_count_i = 2'd0;
    budget = 20;
    while (!credit_error_o && budget > 0) begin tick(); budget--; end
    check("t5_err", credit_error_o, 1'b1);
    check("t5_no_write", writes, 7);
    check("t5_credit_kept", dut.credits_q, 1);
    push_store(32'h500, 32'hCAFEF00D, 4'h6);
    wait_writes(8, "t5_retry");
    tick(); tick();
    check("t5_err_sticky", credit_error_o, 1'b1);

    // Reset while a write is stalled.
    mem_write_ready_i = 1'b0;
    push_store(32'h600, 32'h66666666, 4'h9);
    retire_store_count_i = 2'd1;
    tick(); retire_store_count_i = 2'd0;
    budget = 20;
    while (!mem_write_valid_o && budget > 0) begin tick(); budget--; end
    check("t6_valid_seen", mem_write_valid_o, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_valid", mem_write_valid_o, 1'b0);
    check("t6_addr", mem_write_address_o, 0);
    check("t6_data", mem_write_data_o, 0);
    check("t6_be", mem_write_byte_enable_o, 0);
    check("t6_req", dequeue_request_o, 1'b0);
    check("t6_commit", store_committed_o, 1'b0);
    check("t6_idle", commit_idle_o, 1'b1);
    check("t6_err", credit_error_o, 1'b0);
    check("t6_credits", dut.credits_q, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    reset = 1'b0;
    mem_write_ready_i = 1'b1;
    tick();

    // Credit overflow saturates at DEPTH (queue empty so nothing is consumed).
    retire_store_count_i = 2'd2;
    tick(); retire_store_count_i = 2'd2;
    tick(); check("t5o_err_before", credit_error_o, 1'b0);
    check("t5o_credits_full", dut.credits_q, DEPTH);
    retire_store_count_i = 2'd2;
    tick(); retire_store_count_i = 2'd0;
    check("t5o_credits_sat", dut.credits_q, DEPTH);
    check("t5o_err", credit_error_o, 1'b1);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
